// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported, word-addressed synchronous memory between the
//   fetch (IF) stage and the load/store (MEM) stage of a pipeline.
//   Grants at most one access per cycle, tags every read with its owner, and
//   routes returning read data to the owner MEM_LAT cycles after issue.
//   Fetch responses that are still in flight are dropped when i_flush is high.
//
//   Optional feature: define MEM_ARB_STARVE_EN to add a starvation guard that
//   forces a fetch grant after STARVE_LIMIT consecutive fetch losses to data.
//   Without the macro, data always has strict priority.
//
// Ports
//   clk, rst                       clock (rising edge), synchronous active-high reset
//   i_req/i_addr/i_flush           fetch request, byte address, flush of in-flight fetches
//   i_ready/i_rvalid/i_rdata       fetch grant (comb), response valid, response data
//   d_req/d_we/d_addr/d_wdata      data request, store flag, byte address, store data
//   d_ready/d_rvalid/d_rdata       data grant (comb), load response valid, load data
//   m_en/m_we/m_addr/m_wdata       memory strobe, write enable, word address, write data
//   m_rdata                        memory read data, MEM_LAT cycles after a read strobe
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  input  logic              i_flush,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  // Tag pipe: one {valid, owner} entry per cycle of memory latency.
  // Owner bit 1 = fetch, 0 = data. Index MEM_LAT-1 lines up with m_rdata.
  logic [MEM_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [MEM_LAT-1:0] tag_own_q, tag_own_d;
  logic [31:0]        i_rdata_q, i_rdata_d;
  logic [31:0]        d_rdata_q, d_rdata_d;
  logic               force_fetch_s;
  logic               unused_s;

`ifdef MEM_ARB_STARVE_EN
  localparam logic [1:0] STARVE_LIM = 2'(STARVE_LIMIT);

  logic [1:0] starve_cnt_q, starve_cnt_d;

  // Fetch overrides data once it has lost STARVE_LIMIT times in a row.
  always_comb begin
    force_fetch_s = 1'b0;
    if (!rst && i_req && !i_flush && (starve_cnt_q >= STARVE_LIM)) begin
      force_fetch_s = 1'b1;
    end else begin
      force_fetch_s = 1'b0;
    end
  end

  // Saturating count of consecutive fetch losses to a data grant.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_req || i_flush || i_ready) begin
      starve_cnt_d = 2'd0;
    end else if (d_ready && (starve_cnt_q != 2'd3)) begin
      starve_cnt_d = starve_cnt_q + 2'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= 2'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign unused_s = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};
`else
  assign force_fetch_s = 1'b0;
  assign unused_s = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0],
                      2'(STARVE_LIMIT)};
`endif

  // Same-cycle grant: data wins unless the starvation guard forces fetch;
  // a fetch is never granted during a flush.
  always_comb begin
    i_ready = 1'b0;
    d_ready = 1'b0;
    if (rst) begin
      i_ready = 1'b0;
      d_ready = 1'b0;
    end else if (force_fetch_s) begin
      i_ready = 1'b1;
      d_ready = 1'b0;
    end else begin
      d_ready = d_req;
      i_ready = i_req & ~d_req & ~i_flush;
    end
  end

  // Memory-side request mux driven from the winner; idle drives zeros.
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = 32'd0;
    if (d_ready) begin
      m_en    = 1'b1;
      m_we    = d_we;
      m_addr  = d_addr[ADDR_W+1:2];
      m_wdata = d_wdata;
    end else if (i_ready) begin
      m_en    = 1'b1;
      m_we    = 1'b0;
      m_addr  = i_addr[ADDR_W+1:2];
      m_wdata = 32'd0;
    end else begin
      m_en    = 1'b0;
    end
  end

  // Tag pipe advance. Only reads push a valid entry; a flush kills every
  // fetch entry as it moves (stage 0 never holds a fetch during a flush).
  always_comb begin
    tag_vld_d    = '0;
    tag_own_d    = '0;
    tag_vld_d[0] = (d_ready & ~d_we) | i_ready;
    tag_own_d[0] = i_ready;
    for (int k = 1; k < MEM_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1] & ~(i_flush & tag_own_q[k-1]);
      tag_own_d[k] = tag_own_q[k-1];
    end
  end

  // Response steering at the pipe tail; the tail entry is suppressed
  // combinationally when a flush or reset arrives in the delivery cycle.
  always_comb begin
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    if (rst) begin
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
    end else begin
      i_rvalid = tag_vld_q[MEM_LAT-1] & tag_own_q[MEM_LAT-1] & ~i_flush;
      d_rvalid = tag_vld_q[MEM_LAT-1] & ~tag_own_q[MEM_LAT-1];
    end
    i_rdata   = i_rvalid ? m_rdata : i_rdata_q;
    d_rdata   = d_rvalid ? m_rdata : d_rdata_q;
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
  end

  // Tag pipe and read-data hold registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      tag_own_q <= '0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int AW   = 8;
  localparam int SLIM = 3;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, i_req, i_flush, d_req, d_we;
  logic [31:0]   i_addr, d_addr, d_wdata, m_rdata, m_wdata, i_rdata, d_rdata;
  logic          i_ready, i_rvalid, d_ready, d_rvalid, m_en, m_we;
  logic [AW-1:0] m_addr;

  mem_port_arbiter #(.ADDR_W(AW), .MEM_LAT(LAT), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Initial memory image, shared by the memory and the reference model.
  function automatic logic [31:0] seed(input int a);
    if (a == 1) return 32'h2009000A;
    return {a[7:0], 8'h5A, ~a[7:0], a[7:0] ^ 8'h3C};
  endfunction

  // Synchronous memory with LAT-cycle read latency; idle cycles return junk.
  logic        tb_init;
  logic [31:0] mem [256];
  logic [31:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (tb_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= seed(k);
    end else if (m_en && m_we) begin
      mem[m_addr] <= m_wdata;
    end
    rd_pipe[0] <= (m_en && !m_we) ? mem[m_addr] : $urandom();
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign m_rdata = rd_pipe[LAT-1];

  // Reference model: queue of expected responses with their due cycle.
  typedef struct packed { int due; logic is_i; logic [31:0] data; } resp_t;
  resp_t       q[$];
  logic [31:0] ref_mem [256];
  int          cyc, losses;
  logic [31:0] last_i, last_d;
  int          n_vec, n_err;

  logic          exp_i_ready, exp_d_ready, exp_m_en, exp_m_we, exp_i_rvalid, exp_d_rvalid;
  logic [AW-1:0] exp_m_addr;
  logic [31:0]   exp_m_wdata, exp_i_rdata, exp_d_rdata;

  task automatic predict();
    bit force_i, due_now;
    force_i      = STARVE_ON && !rst && i_req && !i_flush && (losses >= SLIM);
    exp_d_ready  = !rst && d_req && !force_i;
    exp_i_ready  = !rst && i_req && !i_flush && (!d_req || force_i);
    exp_m_en     = exp_i_ready || exp_d_ready;
    exp_m_we     = exp_d_ready && d_we;
    exp_m_addr   = exp_d_ready ? d_addr[AW+1:2] : (exp_i_ready ? i_addr[AW+1:2] : 8'd0);
    exp_m_wdata  = exp_d_ready ? d_wdata : 32'd0;
    due_now      = (q.size() > 0) && (q[0].due == cyc);
    exp_i_rvalid = !rst && due_now && q[0].is_i && !i_flush;
    exp_d_rvalid = !rst && due_now && !q[0].is_i;
    exp_i_rdata  = exp_i_rvalid ? q[0].data : last_i;
    exp_d_rdata  = exp_d_rvalid ? q[0].data : last_d;
  endtask

  task automatic commit();
    resp_t keep[$];
    if (rst) begin
      q.delete(); last_i = 32'd0; last_d = 32'd0; losses = 0;
    end else begin
      if (exp_i_rvalid) last_i = exp_i_rdata;
      if (exp_d_rvalid) last_d = exp_d_rdata;
      if ((q.size() > 0) && (q[0].due == cyc)) void'(q.pop_front());
      if (i_flush) begin
        foreach (q[k]) if (!q[k].is_i) keep.push_back(q[k]);
        q = keep;
      end
      if (exp_i_ready) q.push_back('{due: cyc + LAT, is_i: 1'b1, data: ref_mem[i_addr[AW+1:2]]});
      if (exp_d_ready && !d_we) q.push_back('{due: cyc + LAT, is_i: 1'b0, data: ref_mem[d_addr[AW+1:2]]});
      if (exp_d_ready && d_we) ref_mem[d_addr[AW+1:2]] = d_wdata;
      if (!i_req || i_flush || exp_i_ready) losses = 0;
      else if (exp_d_ready) losses = (losses < 3) ? losses + 1 : 3;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    commit();
  endtask

  task automatic idle();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; i_flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h4; d_addr = 32'h8;
    for (int k = 0; k < 2; k++) begin
      #1; predict();
      n_vec++; if (i_ready !== 1'b0) begin n_err++; $display("FAIL rst_i_ready got %b exp 0", i_ready); end
      n_vec++; if (d_ready !== 1'b0) begin n_err++; $display("FAIL rst_d_ready got %b exp 0", d_ready); end
      n_vec++; if (m_en !== 1'b0) begin n_err++; $display("FAIL rst_m_en got %b exp 0", m_en); end
      tick();
    end
    rst = 1'b0; idle(); #1; predict();
    n_vec++; if (i_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_i_rvalid got %b exp 0", i_rvalid); end
    n_vec++; if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_d_rvalid got %b exp 0", d_rvalid); end
    n_vec++; if (i_rdata !== 32'd0) begin n_err++; $display("FAIL rst_i_rdata got %h exp 0", i_rdata); end
    n_vec++; if (d_rdata !== 32'd0) begin n_err++; $display("FAIL rst_d_rdata got %h exp 0", d_rdata); end
    tick();
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 32'h4; #1; predict();
    n_vec++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL fetch_i_ready got %b exp 1", i_ready); end
    n_vec++; if (m_en !== 1'b1 || m_we !== 1'b0) begin n_err++; $display("FAIL fetch_m_en_we got %b%b exp 10", m_en, m_we); end
    n_vec++; if (m_addr !== 8'h01) begin n_err++; $display("FAIL fetch_m_addr got %h exp 01", m_addr); end
    tick();
    idle();
    for (int k = 1; k <= LAT; k++) begin
      #1; predict();
      n_vec++; if (i_rvalid !== exp_i_rvalid) begin n_err++; $display("FAIL fetch_i_rvalid k=%0d got %b exp %b", k, i_rvalid, exp_i_rvalid); end
      if (k == LAT) begin
        n_vec++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h2009000A) begin n_err++; $display("FAIL fetch_i_rdata got %b/%h exp 1/2009000a", i_rvalid, i_rdata); end
      end
      tick();
    end
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'd15; i_req = 1'b1; i_addr = 32'h40;
    #1; predict();
    n_vec++; if (m_we !== 1'b1 || i_ready !== 1'b0 || d_ready !== 1'b1) begin n_err++; $display("FAIL st_grant got we=%b ir=%b dr=%b exp 1 0 1", m_we, i_ready, d_ready); end
    n_vec++; if (m_wdata !== 32'd15) begin n_err++; $display("FAIL st_m_wdata got %h exp f", m_wdata); end
    tick();
    d_we = 1'b0; #1; predict();
    n_vec++; if (d_ready !== 1'b1 || m_we !== 1'b0 || m_addr !== 8'h00) begin n_err++; $display("FAIL ld_grant got dr=%b we=%b a=%h exp 1 0 00", d_ready, m_we, m_addr); end
    tick();
    idle();
    for (int k = 1; k <= LAT; k++) begin
      #1; predict();
      n_vec++; if (d_rvalid !== exp_d_rvalid) begin n_err++; $display("FAIL ld_d_rvalid k=%0d got %b exp %b", k, d_rvalid, exp_d_rvalid); end
      if (k == LAT) begin
        n_vec++; if (d_rvalid !== 1'b1 || d_rdata !== 32'd15) begin n_err++; $display("FAIL ld_d_rdata got %b/%h exp 1/0000000f", d_rvalid, d_rdata); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    int pulses;
    pulses = 0;
    i_req = 1'b1; i_addr = 32'h18; #1; predict();
    n_vec++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL fl_first_grant got %b exp 1", i_ready); end
    tick();
    i_flush = 1'b1; i_addr = 32'h30; #1; predict();
    n_vec++; if (i_ready !== 1'b0 || m_en !== 1'b0) begin n_err++; $display("FAIL fl_blocked got ir=%b en=%b exp 0 0", i_ready, m_en); end
    tick();
    i_flush = 1'b0; #1; predict();
    n_vec++; if (i_ready !== 1'b1 || m_addr !== 8'h0C) begin n_err++; $display("FAIL fl_redirect got ir=%b a=%h exp 1 0c", i_ready, m_addr); end
    tick();
    idle();
    for (int k = 0; k <= LAT; k++) begin
      #1; predict();
      if (i_rvalid === 1'b1) pulses++;
      n_vec++; if (i_rvalid !== exp_i_rvalid) begin n_err++; $display("FAIL fl_i_rvalid k=%0d got %b exp %b", k, i_rvalid, exp_i_rvalid); end
      tick();
    end
    n_vec++; if (pulses != 1 || i_rdata !== seed(12)) begin n_err++; $display("FAIL fl_resp got pulses=%0d data=%h exp 1 %h", pulses, i_rdata, seed(12)); end
  endtask

  task automatic test_starve();
    logic want_i;
    idle(); tick();
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h100;
    for (int k = 0; k < 8; k++) begin
      d_addr = 32'(k * 4);
      want_i = STARVE_ON && ((k % 4) == 3);
      #1; predict();
      n_vec++; if (i_ready !== want_i || d_ready !== !want_i) begin n_err++; $display("FAIL starve k=%0d got ir=%b dr=%b exp %b %b", k, i_ready, d_ready, want_i, !want_i); end
      n_vec++; if (i_rvalid !== exp_i_rvalid || d_rvalid !== exp_d_rvalid) begin n_err++; $display("FAIL starve_rv k=%0d got %b%b exp %b%b", k, i_rvalid, d_rvalid, exp_i_rvalid, exp_d_rvalid); end
      tick();
    end
    idle();
    for (int k = 0; k <= LAT; k++) begin
      #1; predict();
      n_vec++; if (i_rvalid !== exp_i_rvalid || d_rvalid !== exp_d_rvalid || d_rdata !== exp_d_rdata) begin n_err++; $display("FAIL starve_drain got %b%b %h exp %b%b %h", i_rvalid, d_rvalid, d_rdata, exp_i_rvalid, exp_d_rvalid, exp_d_rdata); end
      tick();
    end
  endtask

  task automatic test_alternating();
    for (int k = 0; k < 12 + LAT + 1; k++) begin
      idle();
      if (k < 12) begin
        if (k % 2 == 0) begin d_req = 1'b1; d_addr = $urandom(); end
        else begin i_req = 1'b1; i_addr = $urandom(); end
      end
      #1; predict();
      n_vec++; if (i_ready !== exp_i_ready || d_ready !== exp_d_ready) begin n_err++; $display("FAIL alt_ready k=%0d got %b%b exp %b%b", k, i_ready, d_ready, exp_i_ready, exp_d_ready); end
      n_vec++; if (i_rvalid !== exp_i_rvalid || d_rvalid !== exp_d_rvalid) begin n_err++; $display("FAIL alt_rvalid k=%0d got %b%b exp %b%b", k, i_rvalid, d_rvalid, exp_i_rvalid, exp_d_rvalid); end
      n_vec++; if (i_rdata !== exp_i_rdata || d_rdata !== exp_d_rdata) begin n_err++; $display("FAIL alt_rdata k=%0d got %h %h exp %h %h", k, i_rdata, d_rdata, exp_i_rdata, exp_d_rdata); end
      n_vec++; if (i_rvalid === 1'b1 && d_rvalid === 1'b1) begin n_err++; $display("FAIL alt_both_rvalid k=%0d got 11 exp not both", k); end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    idle(); d_req = 1'b1; d_addr = 32'h20; tick();
    idle(); i_req = 1'b1; i_addr = 32'h24; tick();
    idle(); rst = 1'b1; tick();
    rst = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      #1; predict();
      n_vec++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_rvalid k=%0d got %b%b exp 00", k, i_rvalid, d_rvalid); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      rst     = ($urandom_range(0, 49) == 0);
      i_req   = $urandom_range(0, 2) != 0;
      d_req   = $urandom_range(0, 1) != 0;
      d_we    = $urandom_range(0, 2) == 0;
      i_flush = $urandom_range(0, 5) == 0;
      i_addr  = $urandom(); d_addr = $urandom(); d_wdata = $urandom();
      #1; predict();
      n_vec++; if (i_ready !== exp_i_ready) begin n_err++; $display("FAIL rnd_i_ready cyc=%0d got %b exp %b", cyc, i_ready, exp_i_ready); end
      n_vec++; if (d_ready !== exp_d_ready) begin n_err++; $display("FAIL rnd_d_ready cyc=%0d got %b exp %b", cyc, d_ready, exp_d_ready); end
      n_vec++; if (m_en !== exp_m_en || m_we !== exp_m_we) begin n_err++; $display("FAIL rnd_m_en_we cyc=%0d got %b%b exp %b%b", cyc, m_en, m_we, exp_m_en, exp_m_we); end
      n_vec++; if (m_addr !== exp_m_addr) begin n_err++; $display("FAIL rnd_m_addr cyc=%0d got %h exp %h", cyc, m_addr, exp_m_addr); end
      n_vec++; if (m_wdata !== exp_m_wdata) begin n_err++; $display("FAIL rnd_m_wdata cyc=%0d got %h exp %h", cyc, m_wdata, exp_m_wdata); end
      n_vec++; if (i_rvalid !== exp_i_rvalid) begin n_err++; $display("FAIL rnd_i_rvalid cyc=%0d got %b exp %b", cyc, i_rvalid, exp_i_rvalid); end
      n_vec++; if (d_rvalid !== exp_d_rvalid) begin n_err++; $display("FAIL rnd_d_rvalid cyc=%0d got %b exp %b", cyc, d_rvalid, exp_d_rvalid); end
      n_vec++; if (i_rdata !== exp_i_rdata) begin n_err++; $display("FAIL rnd_i_rdata cyc=%0d got %h exp %h", cyc, i_rdata, exp_i_rdata); end
      n_vec++; if (d_rdata !== exp_d_rdata) begin n_err++; $display("FAIL rnd_d_rdata cyc=%0d got %h exp %h", cyc, d_rdata, exp_d_rdata); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; losses = 0; last_i = 32'd0; last_d = 32'd0;
    for (int k = 0; k < 256; k++) ref_mem[k] = seed(k);
    tb_init = 1'b1; rst = 1'b1; idle();
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
    #1; predict(); tick();
    tb_init = 1'b0;
    test_reset();
    test_fetch();
    test_store_load();
    test_flush();
    test_starve();
    test_alternating();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
